// File: rtl/pixel_row_readout.sv
// Row readout buffer: snapshots the parallel row bus during a READ window and then
// streams the captured pixels one byte per beat over a valid/ready interface.

package PixelSensorConfig;
  localparam int PIXEL_ARRAY_WIDTH = 4;
endpackage

module pixel_row_readout #(
  parameter int PIXEL_ARRAY_WIDTH = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
  parameter int IDX_W             = $clog2(PIXEL_ARRAY_WIDTH)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                read,
  input  logic [PIXEL_ARRAY_WIDTH-1:0][7:0]   row_data,
  input  logic                                pixel_ready,
  input  logic                                clear_overrun,
  output logic [7:0]                          pixel_data,
  output logic [IDX_W-1:0]                    pixel_index,
  output logic                                pixel_valid,
  output logic                                pixel_last,
  output logic                                busy,
  output logic                                overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_ARRAY_WIDTH - 1);

  state_t                              state;
  logic [IDX_W-1:0]                    idx;
  logic [PIXEL_ARRAY_WIDTH-1:0][7:0]   row_buf;
  logic                                read_q;

  logic read_rise;
  logic handshake;
  logic at_last;
  logic row_done;

  assign read_rise = read & ~read_q;
  assign handshake = (state == STREAM) & pixel_ready;
  assign at_last   = (idx == LAST_IDX);
  assign row_done  = handshake & at_last;

  // A fresh READ window that lands exactly on the final handshake chains straight
  // into the next capture; any other rise during a stream is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      row_buf <= '0;
      read_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      read_q <= read;

      if ((state == STREAM) && read_rise && !row_done) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (read_rise) begin
            row_buf <= row_data;
            state   <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (read) begin
            row_buf <= row_data;
          end else begin
            idx   <= '0;
            state <= STREAM;
          end
        end

        STREAM: begin
          if (handshake) begin
            if (at_last) begin
              idx <= '0;
              if (read_rise) begin
                row_buf <= row_data;
                state   <= CAPTURE;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign pixel_valid = (state == STREAM);
  assign pixel_data  = row_buf[idx];
  assign pixel_index = idx;
  assign pixel_last  = pixel_valid & at_last;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_pixel_row_readout.sv
// Directed bench for pixel_row_readout at W=4: basic stream, last-capture-wins,
// backpressure, overrun, back-to-back rows and reset mid-stream.

module tb_pixel_row_readout;

  localparam int W     = 4;
  localparam int IDX_W = 2;

  logic                 clk;
  logic                 reset;
  logic                 read;
  logic [W-1:0][7:0]    row_data;
  logic                 pixel_ready;
  logic                 clear_overrun;
  logic [7:0]           pixel_data;
  logic [IDX_W-1:0]     pixel_index;
  logic                 pixel_valid;
  logic                 pixel_last;
  logic                 busy;
  logic                 overrun;

  int checks   = 0;
  int failures = 0;

  pixel_row_readout #(
    .PIXEL_ARRAY_WIDTH(W),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .read(read),
    .row_data(row_data),
    .pixel_ready(pixel_ready),
    .clear_overrun(clear_overrun),
    .pixel_data(pixel_data),
    .pixel_index(pixel_index),
    .pixel_valid(pixel_valid),
    .pixel_last(pixel_last),
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic clr);
    read          = r;
    pixel_ready   = rdy;
    clear_overrun = clr;
  endtask

  // Packed view {busy, valid, last, overrun, index, data}; data is only compared when asked.
  task automatic checkOutput(input string tag, input logic exp_busy, input logic exp_valid,
                             input logic exp_last, input logic exp_ovr,
                             input logic [IDX_W-1:0] exp_idx, input logic [7:0] exp_data,
                             input logic check_data);
    logic [IDX_W+11:0] obs;
    logic [IDX_W+11:0] expv;
    obs  = {busy, pixel_valid, pixel_last, overrun, pixel_index,
            (check_data ? pixel_data : 8'h00)};
    expv = {exp_busy, exp_valid, exp_last, exp_ovr, exp_idx,
            (check_data ? exp_data : 8'h00)};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h (busy,valid,last,ovr,idx,data)", tag, obs, expv);
    end
  endtask

  task automatic checkCount(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input int k, input logic [W-1:0][7:0] row,
                           input logic exp_ovr);
    checkOutput(tag, 1'b1, 1'b1, (k == W-1), exp_ovr, IDX_W'(k), row[k], 1'b1);
  endtask

  task automatic streamRow(input string tag, input logic [W-1:0][7:0] row, input logic exp_ovr);
    for (int k = 0; k < W; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkBeat(tag, k, row, exp_ovr);
      tick();
    end
  endtask

  logic [W-1:0][7:0] row_a;
  logic [W-1:0][7:0] row_b;
  logic [W-1:0][7:0] row_old;
  logic [W-1:0][7:0] row_new;

  initial begin
    int k;
    int hs;
    int cyc;
    logic rdy;

    row_a   = {8'h40, 8'h30, 8'h20, 8'h10};
    row_b   = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    row_old = {8'h99, 8'h88, 8'h77, 8'h11};
    row_new = {8'h44, 8'h33, 8'h22, 8'h11};

    reset    = 1'b1;
    row_data = row_a;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    reset = 1'b0;

    // Basic stream: read high for five cycles.
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("basic_busy_rise", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("basic_capture_hold", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    streamRow("basic_beat", row_a, 1'b0);
    checkOutput("basic_idle_after", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

    // Last capture wins.
    row_data = row_old;
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    tick();
    row_data = row_new;
    tick();
    row_data = row_a;
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    streamRow("lastwins_beat", row_new, 1'b0);
    checkOutput("lastwins_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

    // Backpressure with ready pattern 1,0,0,1,0,0,...
    row_data = row_a;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    k   = 0;
    hs  = 0;
    cyc = 0;
    while (k < W && cyc < 40) begin
      rdy = ((cyc % 3) == 0);
      applyStimulus(1'b0, rdy, 1'b0);
      checkBeat("bp_beat", k, row_a, 1'b0);
      tick();
      if (rdy) begin
        k++;
        hs++;
      end
      cyc++;
    end
    checkCount("bp_handshakes", hs, W);
    checkCount("bp_cycles", cyc, 10);
    checkOutput("bp_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

    // Overrun: second READ window while stalled mid-stream.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("ovr_pre", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h10, 1'b1);
    row_data = row_b;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("ovr_set", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h10, 1'b1);
    tick();
    checkOutput("ovr_held_read", 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 8'h10, 1'b1);
    row_data = row_a;
    streamRow("ovr_beat", row_a, 1'b1);
    checkOutput("ovr_idle_sticky", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ovr_cleared", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

    // Back-to-back: new rise on the final handshake.
    row_data = row_a;
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < W - 1; i++) begin
      checkBeat("b2b_first", i, row_a, 1'b0);
      tick();
    end
    checkBeat("b2b_first_last", W - 1, row_a, 1'b0);
    row_data = row_b;
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("b2b_recapture", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    row_data = row_a;
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    streamRow("b2b_second", row_b, 1'b0);
    checkOutput("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

    // Reset mid-stream after the second beat.
    row_data = row_a;
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkBeat("rst_beat0", 0, row_a, 1'b0);
    tick();
    checkBeat("rst_beat1", 1, row_a, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_outputs", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    streamRow("rst_restream", row_a, 1'b0);
    checkOutput("rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_row_readout.md
# pixel_row_readout

Row readout buffer on the consumer end of the pixel row READ bus. While the row controller holds READ, the block snapshots the full parallel row word `DATA_OUT`. Once READ drops, it streams the captured pixels one 8-bit value at a time over a valid/ready interface, from pixel 0 to pixel `PIXEL_ARRAY_WIDTH-1`. It sits between the pixel row array and the downstream frame/serial logic, and flags any READ window that arrives while a stream is still in progress.

## Interface
- `PIXEL_ARRAY_WIDTH`, default `PixelSensorConfig::PIXEL_ARRAY_WIDTH`: number of pixels per row; must be ≥ 2.
- `IDX_W`, default `$clog2(PIXEL_ARRAY_WIDTH)`: width of the pixel index.
- Clocking and reset: one clock, `clk`. Reset `reset` is synchronous and active-high.
- `clk` in 1: system clock; all state changes on posedge.
- `reset` in 1: synchronous, active-high.
- `read` in 1: READ strobe from the row controller; high for one or more cycles per row.
- `row_data` in `[PIXEL_ARRAY_WIDTH-1:0][7:0]`: parallel row bus, `[i]` is pixel i.
- `pixel_ready` in 1: downstream accepts the current beat.
- `clear_overrun` in 1: clears the sticky `overrun` flag.
- `pixel_data` out 8: current pixel value.
- `pixel_index` out `IDX_W`: index of the current pixel.
- `pixel_valid` out 1: beat valid.
- `pixel_last` out 1: current beat is pixel `PIXEL_ARRAY_WIDTH-1`.
- `busy` out 1: block is not IDLE.
- `overrun` out 1: sticky flag; a READ window was dropped.

## Operation
- **Edge detect:** `read_q` is `read` registered. A read rise is `read & ~read_q`. `read_q` resets to 0, so `read` held high out of reset counts as a rise.
- **States:** IDLE, CAPTURE, STREAM.
- **IDLE:**
  - On a read rise, load `buf <= row_data` and go to CAPTURE.
- **CAPTURE:**
  - While `read`=1, reload `buf <= row_data` every cycle, so the last cycle of the READ window wins.
  - When `read`=0, go to STREAM with `idx <= 0`. `buf` is not loaded on this cycle.
- **STREAM:**
  - `pixel_valid`=1, `pixel_data`=`buf[idx]`, `pixel_index`=`idx`.
  - A handshake is `pixel_valid & pixel_ready`.
  - Handshake with `idx` < W-1: `idx <= idx+1`.
  - Handshake with `idx` == W-1 and no read rise: go to IDLE, `idx <= 0`.
  - Handshake with `idx` == W-1 and a read rise on the same cycle: go directly to CAPTURE, load `buf`, no overrun.
  - Read rise on any other STREAM cycle: `overrun <= 1`. `buf` is unchanged, the stream continues, and the dropped window is never captured. Because capture requires a fresh rise, a still-high `read` after the stream ends is ignored.
- **Outputs and flags:**
  - `pixel_last` = `pixel_valid & (idx == W-1)`.
  - `busy` = (state != IDLE).
  - `overrun` is set as above. It is cleared by `clear_overrun` or `reset`. If set and clear occur on the same cycle, set wins.
- **Reset:** state IDLE, `idx` 0, `buf` all 0, `read_q` 0, `overrun` 0. Reset mid-stream abandons the row; there is no partial output after reset.

## Timing
- **Reset values of outputs:** `pixel_data` 0x00, `pixel_index` 0, `pixel_valid` 0, `pixel_last` 0, `busy` 0, `overrun` 0.
- **Output sourcing:** all outputs are decoded from registers only (state, `idx`, `buf`, `overrun`). There is no combinational path from any input to any output.
- **`busy` latency:** `busy` rises the cycle after the posedge that samples the read rise.
- **First beat:** `pixel_valid` rises the cycle after the posedge that samples `read`=0 in CAPTURE.
- **Throughput:** with `pixel_ready` held at 1, one beat per cycle; a row takes W cycles in STREAM.
- **Backpressure:** while `pixel_valid`=1 and `pixel_ready`=0, `pixel_data`, `pixel_index` and `pixel_last` are held stable. `pixel_valid` never drops before its handshake.
- **End of row:** `busy` and `pixel_valid` drop the cycle after the last handshake, unless a new capture starts on that same cycle.

## Test plan
All scenarios use W=4 and `row_data` = {0x40,0x30,0x20,0x10} (pixel 0 = 0x10), unless noted.
- **Basic stream:** reset, `read` high 5 cycles, `pixel_ready`=1 → four consecutive beats 0x10, 0x20, 0x30, 0x40 with index 0..3. `pixel_last` is high only on 0x40. `busy` is 0 one cycle later and `overrun` stays 0.
- **Last capture wins:** `row_data` changes from {..,0x11} to {0x44,0x33,0x22,0x11} on the final read cycle → stream is 0x11, 0x22, 0x33, 0x44.
- **Backpressure:** `pixel_ready` toggles 1,0,0,1,... → each value is held while `pixel_ready`=0. The order is unchanged and 4 handshakes occur in total.
- **Overrun:** `pixel_ready`=0, then a second read pulse during STREAM → `overrun`=1 and the stream still yields the original 0x10..0x40. `clear_overrun` for 1 cycle → `overrun`=0.
- **Back-to-back:** a read rise coincides with the final handshake → no overrun, `busy` stays 1, and the second row streams with the new data.
- **Reset mid-stream:** `reset` after the 2nd beat → the next cycle shows all outputs at their reset values. A fresh read pulse then streams the full row from index 0.
